// File: rtl/mem_loader_pkg.sv
// Shared sizing, default-weight constants and FSM state encoding for mem_loader.
package mem_loader_pkg;

    localparam int unsigned WIDTH = 5;
    localparam int unsigned N_X   = 4;
    localparam int unsigned N_W   = 16;

    localparam logic [4:0] DIAG_W    = 5'b01000;
    localparam logic [4:0] OFFDIAG_W = 5'b11110;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_X,
        LOAD_W,
        DONE
    } state_t;

    // W is a row-major 4x4 matrix: element i is on the diagonal when row == column.
    function automatic logic [4:0] default_w(input int unsigned i);
        return ((i / 4) == (i % 4)) ? DIAG_W : OFFDIAG_W;
    endfunction

endpackage

// File: rtl/mem_loader.sv
// Streams an X vector and a 4x4 weight matrix into registers from a valid/ready source;
// optionally substitutes a built-in weight fill and streams X only.
module mem_loader #(
    parameter int unsigned WIDTH = mem_loader_pkg::WIDTH,
    parameter int unsigned N_X   = mem_loader_pkg::N_X,
    parameter int unsigned N_W   = mem_loader_pkg::N_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             use_default,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] X_out [N_X],
    output logic [WIDTH-1:0] W_out [N_W],
    output logic             busy,
    output logic             done
);

    import mem_loader_pkg::*;

    localparam int unsigned N_MAX = (N_X > N_W) ? N_X : N_W;
    localparam int unsigned CNT_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             use_def_q;

    // Element writes decode the counter per element so no out-of-range index is ever formed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            use_def_q <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int unsigned k = 0; k < N_X; k++) X_out[k] <= '0;
            for (int unsigned k = 0; k < N_W; k++) W_out[k] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= LOAD_X;
                        cnt       <= '0;
                        use_def_q <= use_default;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        if (use_default) begin
                            for (int unsigned k = 0; k < N_W; k++)
                                W_out[k] <= WIDTH'($signed(default_w(k)));
                        end
                    end
                end

                LOAD_X: begin
                    if (in_valid) begin
                        for (int unsigned k = 0; k < N_X; k++)
                            if (cnt == CNT_W'(k)) X_out[k] <= in_data;
                        if (cnt == CNT_W'(N_X - 1)) begin
                            cnt <= '0;
                            if (use_def_q) begin
                                state    <= DONE;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                            end else begin
                                state <= LOAD_W;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                LOAD_W: begin
                    if (in_valid) begin
                        for (int unsigned k = 0; k < N_W; k++)
                            if (cnt == CNT_W'(k)) W_out[k] <= in_data;
                        if (cnt == CNT_W'(N_W - 1)) begin
                            cnt      <= '0;
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter WIDTH, default 5: bit width of every X and W element.
REQ-002 Parameter N_X, default 4: number of X elements.
REQ-003 Parameter N_W, default 16: number of W elements, a 4x4 matrix stored row-major, W[i] = row i/4, column i%4.
REQ-004 clk  input  1: single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous and active-low.
REQ-006 start  input  1: begin a load session; sampled only in IDLE and DONE.
REQ-007 use_default  input  1: sampled with start; 1 selects a built-in W fill and streams X only.
REQ-008 in_valid  input  1: producer has a word on in_data.
REQ-009 in_data  input  WIDTH: streamed word, two's complement.
REQ-010 in_ready  output  1: loader accepts a word this cycle.
REQ-011 X_out  output  WIDTH x N_X unpacked array: loaded X vector.
REQ-012 W_out  output  WIDTH x N_W unpacked array: loaded weight matrix.
REQ-013 busy  output  1: high in LOAD_X and LOAD_W.
REQ-014 done  output  1: high in DONE; X_out and W_out are complete and stable.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD_X, LOAD_W and DONE.
REQ-016 IDLE or DONE with start=1 SHALL go to LOAD_X and clear the element counter to 0; a start pulse that sets use_default=1 SHALL also write the default fill into W_out on that same edge.
REQ-017 The default fill SHALL set W[i] to 5'b01000 (+8) when i is 0, 5, 10 or 15, and to 5'b11110 (-2) for every other i.
REQ-018 in_ready SHALL equal 1 exactly when the state is LOAD_X or LOAD_W; the signal is registered-state decoded, with no combinational path from in_valid.
REQ-019 A beat SHALL transfer when in_valid=1 and in_ready=1 at a rising edge; in_valid=0 stalls the loader with no state change.
REQ-020 LOAD_X SHALL write beat k to X_out[k] for k = 0..N_X-1.
REQ-021 After beat N_X-1, LOAD_X SHALL go to DONE when use_default=1 was latched and to LOAD_W otherwise, and SHALL reset the counter to 0.
REQ-022 LOAD_W SHALL write beat k to W_out[k] for k = 0..N_W-1 and SHALL go to DONE after beat N_W-1.
REQ-023 Latency: done SHALL rise on the edge that accepts the last beat, so a session with no stalls takes N_X+N_W cycles, or N_X cycles with use_default.
REQ-024 DONE SHALL hold X_out and W_out unchanged until the next start.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 A new session SHALL overwrite only the elements it writes; elements not yet rewritten keep their previous values until their own beat arrives.
REQ-027 The element counter SHALL be ceil(log2(max(N_X,N_W))) bits wide and SHALL never index past N_X-1 in LOAD_X or past N_W-1 in LOAD_W.
REQ-028 in_data SHALL be stored unmodified, with no sign extension or saturation.

Reset
REQ-029 rst_n=0 SHALL force state IDLE, counter 0, every X_out and W_out element 0, and in_ready, busy and done 0, immediately and regardless of clk.
REQ-030 Reset in the middle of a session SHALL abort it; after release the loader waits in IDLE for start.

Structure
REQ-031 A shared package SHALL hold WIDTH, N_X, N_W, the DIAG_W (5'b01000) and OFFDIAG_W (5'b11110) constants, and the state enum.
REQ-032 There are no sub-modules; the FSM, counter and storage SHALL sit in mem_loader.

Verification
REQ-033 Drive start, use_default=0, then 20 back-to-back beats with values 1..20 -> X_out = {1,2,3,4}, W_out[k] = k+5, done rises at cycle 20, in_ready is 0 afterwards.
REQ-034 Drive start, use_default=1, then 4 beats 3,-1,7,0 -> done after 4 beats, W_out is the diagonal +8 / off-diagonal -2 pattern, X_out = {3,-1,7,0}.
REQ-035 Insert random in_valid=0 gaps during a full session -> same final contents as REQ-033, and no beat is lost or duplicated.
REQ-036 Pulse start again in LOAD_W at element 7 -> the pulse is ignored and the session completes normally.
REQ-037 Assert rst_n=0 after 10 beats, asynchronous to clk -> all outputs are 0 at once; after release, a new session loads correctly.
REQ-038 In DONE, hold in_valid=1 with changing data for 5 cycles -> in_ready stays 0 and the outputs stay unchanged.
